serial_mem_host: RTL and testbench
==================================

# serial_mem_host

Synthesizable, parametrised host for the CPU core's byte-serial memory bus. It replaces the external microcontroller that serves instruction fetches and data loads/stores. It holds an instruction memory and a data memory, captures serialised addresses and store data from the core, and streams fetched or loaded words back byte by byte. It sits beside `cpu_core` at the top level, and also serves as the memory model for system-level benches.

## Interface
- `WORD_W`, 16: CPU word width; must be a multiple of `BUS_W`.
- `BUS_W`, 8: serial bus width. BYTES = `WORD_W`/`BUS_W`.
- `IMEM_DEPTH`, 16: instruction words; power of two.
- `DMEM_DEPTH`, 16: data words; power of two.
- `FETCH_WORDS`, 2: words returned per fetch (instruction + immediate); 1..4.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `out_bus` in `BUS_W`: byte from core (address/store data).
- `bus_pc` in 1: core strobe; fetch-address byte 0 is on `out_bus` this cycle.
- `bus_mar` in 1: core strobe; data-address byte 0 is on `out_bus` this cycle.
- `bus_mdr` in 1: qualifies `bus_mar`: 1 = store, 0 = load.
- `in_bus` out `BUS_W`: byte to core.
- `ard_data_ready` out 1: `in_bus` valid this cycle.
- `ard_receive_ready` out 1: host accepts a new strobe.
- `imem_we` in 1: preload write enable.
- `imem_waddr` in log2(`IMEM_DEPTH`): preload address.
- `imem_wdata` in `WORD_W`: preload data.
- `dmem_raddr` in log2(`DMEM_DEPTH`): debug read address (combinational).
- `dmem_rdata` out `WORD_W`: debug read data.
- `err` out 1: sticky protocol/range error. Cleared only by `rst`.

## Operation
- All multi-byte values are sent least-significant byte first. The byte on `out_bus` in the strobe cycle is byte 0.
- States: IDLE, ADDR, WDATA, SEND.
- IDLE: `ard_receive_ready`=1. On `bus_pc`, capture byte 0, set mode=FETCH, go to ADDR. On `bus_mar`, capture byte 0, set mode=STORE if `bus_mdr` else LOAD, go to ADDR. If BYTES==1, skip ADDR and go straight to the next state.
- If `bus_pc` and `bus_mar` are both asserted in the same cycle, FETCH wins and `err` is set.
- ADDR: capture bytes 1..BYTES-1 on consecutive cycles, with no gaps and no qualifier. After the last byte: STORE goes to WDATA; FETCH and LOAD go to SEND.
- WDATA: capture BYTES data bytes on consecutive cycles. On the last byte, write `dmem[addr]` and return to IDLE.
- SEND: drive N×BYTES bytes with `ard_data_ready`=1 every cycle, where N=`FETCH_WORDS` for FETCH and N=1 for LOAD. Then return to IDLE.
  - FETCH word i = `imem[(addr+i) mod IMEM_DEPTH]`. Wrap-around is legal and does not set `err`.
  - LOAD word = `dmem[addr]`.
- Data range rule: if addr ≥ `DMEM_DEPTH`, a store is dropped and a load returns 0. Both set `err`, and all bytes are still consumed or sent.
- Any strobe outside IDLE is ignored and sets `err`. `ard_receive_ready` is 1 in IDLE, ADDR and WDATA, and 0 in SEND.
- Preload: `imem_we` writes on posedge in any state. If it targets the word being read in the same cycle, the read returns the old data.
- The full `WORD_W` address is captured; the range check uses all bits.

## Timing
- Reset values: state IDLE, `in_bus`=0, `ard_data_ready`=0, `ard_receive_ready`=0, `err`=0, and all capture registers 0.
- Memories are not cleared by reset.
- `ard_receive_ready` rises on the first posedge after `rst` is released.
- Outputs are registered. Let strobe cycle = T.
  - Last address byte is at T+BYTES-1.
  - First response byte is on `in_bus` at T+BYTES.
  - Response bytes are contiguous through T+BYTES+N×BYTES-1.
- `ard_data_ready` drops to 0 in the cycle after the last byte. `in_bus` returns to 0 whenever `ard_data_ready`=0.
- Store: the memory write occurs on the posedge ending cycle T+2×BYTES-1. `dmem_rdata` reflects the new data from T+2×BYTES.
- IDLE is re-entered the cycle after a transaction ends, so a new strobe is accepted in that cycle. Back-to-back transactions therefore have zero dead cycles.
- `rst` mid-transaction aborts it: any partial store is discarded and the outputs take their reset values on the next posedge.

## Test plan
- Fetch with defaults. Preload `imem[0]`=16'h0A11 and `imem[1]`=16'h0001. Strobe `bus_pc` with address bytes 00,00. Required: `in_bus` = 11,0A,01,00 at T+2..T+5 with `ard_data_ready`=1, then 0; `err`=0.
- Store then load. Store addr 0, data 3: bytes 00,00 then 03,00 under `bus_mar` with `bus_mdr`=1. Required: `dmem_rdata`@0 = 3 at T+4. Then load addr 0. Required: `in_bus` 03,00.
- Fetch wrap-around. Fetch at addr 15 with `imem[15]`=16'hBEEF and `imem[0]`=16'h1234. Required: bytes EF,BE,34,12; `err`=0.
- Out-of-range data access. Store to addr 16 leaves `dmem` unchanged and sets `err`=1. Load from addr 20 returns 00,00.
- Protocol violations. Assert `bus_mar` during SEND: it is ignored, the stream completes intact, and `err`=1. Assert `bus_pc` and `bus_mar` together in IDLE: a fetch is performed and `err`=1.
- Reset mid-operation. Assert `rst` during the second response byte. Required: next cycle `ard_data_ready`=0, `ard_receive_ready`=0, `err`=0. After release, a new fetch works and preloaded `imem` is intact.

Source files
------------

// File: rtl/serial_mem_host.sv
// serial_mem_host: memory host for the core's byte-serial bus.
// Serves instruction fetches from imem and loads/stores against dmem.
// Addresses and store data arrive LSB first; responses leave LSB first.
module serial_mem_host #(
    parameter  int WORD_W      = 16,
    parameter  int BUS_W       = 8,
    parameter  int IMEM_DEPTH  = 16,
    parameter  int DMEM_DEPTH  = 16,
    parameter  int FETCH_WORDS = 2,
    localparam int IAW         = $clog2(IMEM_DEPTH),
    localparam int DAW         = $clog2(DMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BUS_W-1:0]  out_bus,
    input  logic              bus_pc,
    input  logic              bus_mar,
    input  logic              bus_mdr,
    output logic [BUS_W-1:0]  in_bus,
    output logic              ard_data_ready,
    output logic              ard_receive_ready,
    input  logic              imem_we,
    input  logic [IAW-1:0]    imem_waddr,
    input  logic [WORD_W-1:0] imem_wdata,
    input  logic [DAW-1:0]    dmem_raddr,
    output logic [WORD_W-1:0] dmem_rdata,
    output logic              err
);
    localparam int BYTES     = WORD_W / BUS_W;
    localparam int MAX_BYTES = FETCH_WORDS * BYTES;
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WDATA, S_SEND} state_t;
    typedef enum logic [1:0] {M_FETCH, M_LOAD, M_STORE} mode_t;

    logic [WORD_W-1:0] imem [IMEM_DEPTH];
    logic [WORD_W-1:0] dmem [DMEM_DEPTH];

    state_t            state, state_n;
    mode_t             mode, mode_n;
    logic [WORD_W-1:0] addr_q, addr_n, wdata_q, wdata_n;
    logic [CNT_W-1:0]  cnt, cnt_n, last_idx;
    logic              err_n, send_n, addr_done, dmem_we;
    logic [BUS_W-1:0]  byte_n;
    logic [WORD_W-1:0] rd_addr, rd_word;
    logic              rd_fetch;
    logic [CNT_W-1:0]  rd_idx, rd_w, rd_b;

    // The whole captured address is range-checked, not just the index bits.
    function automatic logic in_range(input logic [WORD_W-1:0] a);
        return (a >> DAW) == '0;
    endfunction

    // Next-state, capture and response-byte selection.
    always_comb begin
        state_n   = state;
        mode_n    = mode;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        cnt_n     = cnt;
        err_n     = err;
        send_n    = 1'b0;
        addr_done = 1'b0;
        dmem_we   = 1'b0;
        last_idx  = (mode == M_FETCH) ? CNT_W'(MAX_BYTES - 1) : CNT_W'(BYTES - 1);
        rd_addr   = addr_q;
        rd_fetch  = (mode == M_FETCH);
        rd_idx    = cnt + CNT_W'(1);
        rd_word   = '0;
        unique case (state)
            S_IDLE: begin
                if (bus_pc || bus_mar) begin
                    if (bus_pc && bus_mar) err_n = 1'b1;
                    mode_n    = bus_pc ? M_FETCH : (bus_mdr ? M_STORE : M_LOAD);
                    addr_n    = WORD_W'(out_bus);
                    cnt_n     = CNT_W'(1);
                    addr_done = (BYTES == 1);
                    if (BYTES > 1) state_n = S_ADDR;
                end
            end
            S_ADDR: begin
                addr_n    = addr_q | (WORD_W'(out_bus) << (cnt * BUS_W));
                cnt_n     = cnt + CNT_W'(1);
                addr_done = (cnt == CNT_W'(BYTES - 1));
            end
            S_WDATA: begin
                wdata_n = wdata_q | (WORD_W'(out_bus) << (cnt * BUS_W));
                cnt_n   = cnt + CNT_W'(1);
                if (cnt == CNT_W'(BYTES - 1)) begin
                    dmem_we = in_range(addr_q);
                    state_n = S_IDLE;
                end
            end
            S_SEND: begin
                if (cnt == last_idx) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n  = cnt + CNT_W'(1);
                    send_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Strobes outside IDLE are dropped but flagged.
        if (state != S_IDLE && (bus_pc || bus_mar)) err_n = 1'b1;
        // Address complete: launch data phase or first response byte now so
        // the registered output lands exactly BYTES cycles after the strobe.
        if (addr_done) begin
            cnt_n = '0;
            if (mode_n != M_FETCH && !in_range(addr_n)) err_n = 1'b1;
            if (mode_n == M_STORE) begin
                state_n = S_WDATA;
                wdata_n = '0;
            end else begin
                state_n  = S_SEND;
                send_n   = 1'b1;
                rd_addr  = addr_n;
                rd_fetch = (mode_n == M_FETCH);
                rd_idx   = '0;
            end
        end
        rd_w = rd_idx / CNT_W'(BYTES);
        rd_b = rd_idx % CNT_W'(BYTES);
        if (rd_fetch)                rd_word = imem[rd_addr[IAW-1:0] + IAW'(rd_w)];
        else if (in_range(rd_addr)) rd_word = dmem[rd_addr[DAW-1:0]];
        byte_n = BUS_W'(rd_word >> (rd_b * BUS_W));
    end

    // State, capture and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            mode              <= M_FETCH;
            addr_q            <= '0;
            wdata_q           <= '0;
            cnt               <= '0;
            err               <= 1'b0;
            in_bus            <= '0;
            ard_data_ready    <= 1'b0;
            ard_receive_ready <= 1'b0;
        end else begin
            state             <= state_n;
            mode              <= mode_n;
            addr_q            <= addr_n;
            wdata_q           <= wdata_n;
            cnt               <= cnt_n;
            err               <= err_n;
            in_bus            <= send_n ? byte_n : '0;
            ard_data_ready    <= send_n;
            ard_receive_ready <= (state_n != S_SEND);
        end
    end

    // Preload port; a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (imem_we) imem[imem_waddr] <= imem_wdata;
    end

    // Store commit on the last data byte; reset discards it.
    always_ff @(posedge clk) begin
        if (dmem_we && !rst) dmem[addr_q[DAW-1:0]] <= wdata_n;
    end

    assign dmem_rdata = dmem[dmem_raddr];
endmodule

// File: tb/tb_serial_mem_host.sv
// Bench for serial_mem_host: directed transactions, response bytes checked
// by a negedge monitor against a queue of hand-computed expected bytes.
module tb_serial_mem_host;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  out_bus = '0;
    logic        bus_pc = 1'b0, bus_mar = 1'b0, bus_mdr = 1'b0;
    logic [7:0]  in_bus;
    logic        ard_data_ready, ard_receive_ready, err;
    logic        imem_we = 1'b0;
    logic [3:0]  imem_waddr = '0;
    logic [15:0] imem_wdata = '0;
    logic [3:0]  dmem_raddr = '0;
    logic [15:0] dmem_rdata;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    serial_mem_host dut (
        .clk(clk), .rst(rst), .out_bus(out_bus), .bus_pc(bus_pc),
        .bus_mar(bus_mar), .bus_mdr(bus_mdr), .in_bus(in_bus),
        .ard_data_ready(ard_data_ready), .ard_receive_ready(ard_receive_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid byte must match the next expected byte.
    always @(negedge clk) begin
        if (ard_data_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_byte: got %0h expected none", in_bus);
            end else begin
                chk("in_bus", 32'(in_bus), 32'(exp_q.pop_front()));
            end
        end else begin
            chk("in_bus_idle_zero", 32'(in_bus), 32'h0);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
        cycle();
        imem_we = 1'b0;
    endtask

    // Strobe cycle T plus address byte 1; returns at cycle T+2.
    task automatic send_addr(input logic pc, input logic mar, input logic mdr, input logic [15:0] a);
        out_bus = a[7:0]; bus_pc = pc; bus_mar = mar; bus_mdr = mdr;
        cycle();
        bus_pc = 1'b0; bus_mar = 1'b0; bus_mdr = 1'b0; out_bus = a[15:8];
        chk("rcv_ready_addr", 32'(ard_receive_ready), 32'h1);
        cycle();
        out_bus = '0;
    endtask

    // Called at T+2: response must be contiguous for n cycles, then drop.
    task automatic stream(input int n, input bit intrude);
        chk("first_byte_ready", 32'(ard_data_ready), 32'h1);
        chk("rcv_ready_send", 32'(ard_receive_ready), 32'h0);
        for (int k = 1; k < n; k++) begin
            if (intrude && k == 1) bus_mar = 1'b1;
            cycle();
            bus_mar = 1'b0;
        end
        chk("last_byte_ready", 32'(ard_data_ready), 32'h1);
        cycle();
        chk("ready_drop", 32'(ard_data_ready), 32'h0);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        chk("rcv_ready_idle", 32'(ard_receive_ready), 32'h1);
    endtask

    task automatic fetch(input logic [15:0] a, input logic [15:0] w0, input logic [15:0] w1);
        push_word(w0);
        push_word(w1);
        send_addr(1'b1, 1'b0, 1'b0, a);
        stream(4, 1'b0);
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] w, input bit intrude);
        push_word(w);
        send_addr(1'b0, 1'b1, 1'b0, a);
        stream(2, intrude);
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d,
                         input logic [3:0] raddr, input logic [15:0] exp_rd);
        dmem_raddr = raddr;
        send_addr(1'b0, 1'b1, 1'b1, a);
        out_bus = d[7:0];
        cycle();
        out_bus = d[15:8];
        cycle();
        out_bus = '0;
        chk("dmem_rdata_after_store", 32'(dmem_rdata), 32'(exp_rd));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cycle();
        cycle();
        chk("rst_in_bus", 32'(in_bus), 32'h0);
        chk("rst_data_ready", 32'(ard_data_ready), 32'h0);
        chk("rst_rcv_ready", 32'(ard_receive_ready), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst = 1'b0;
        cycle();
        chk("rcv_ready_after_rst", 32'(ard_receive_ready), 32'h1);

        preload(4'd0, 16'h0A11);
        preload(4'd1, 16'h0001);
        preload(4'd15, 16'hBEEF);

        // Basic fetch.
        fetch(16'h0000, 16'h0A11, 16'h0001);
        chk("err_after_fetch", 32'(err), 32'h0);

        // Store then load, two data patterns.
        store(16'h0000, 16'h0003, 4'd0, 16'h0003);
        load(16'h0000, 16'h0003, 1'b0);
        store(16'h0005, 16'hA5C3, 4'd5, 16'hA5C3);
        load(16'h0005, 16'hA5C3, 1'b0);
        chk("err_after_ldst", 32'(err), 32'h0);

        // Fetch wrap-around.
        preload(4'd0, 16'h1234);
        fetch(16'h000F, 16'hBEEF, 16'h1234);
        chk("err_after_wrap", 32'(err), 32'h0);

        // Out-of-range store (low bits alias word 0) and load.
        store(16'h0010, 16'hFFFF, 4'd0, 16'h0003);
        chk("err_oor_store", 32'(err), 32'h1);
        load(16'h0014, 16'h0000, 1'b0);
        chk("err_oor_load", 32'(err), 32'h1);

        // Strobe during SEND is ignored.
        do_reset();
        chk("err_cleared", 32'(err), 32'h0);
        load(16'h0000, 16'h0003, 1'b1);
        chk("err_strobe_in_send", 32'(err), 32'h1);

        // Simultaneous strobes: fetch wins.
        do_reset();
        push_word(16'h1234);
        push_word(16'h0001);
        send_addr(1'b1, 1'b1, 1'b0, 16'h0000);
        stream(4, 1'b0);
        chk("err_dual_strobe", 32'(err), 32'h1);

        // Reset during the second response byte of a dual-strobe fetch.
        push_word(16'h1234);
        send_addr(1'b1, 1'b1, 1'b0, 16'h0000);
        chk("abort_first_byte", 32'(ard_data_ready), 32'h1);
        cycle();
        rst = 1'b1;
        cycle();
        chk("abort_data_ready", 32'(ard_data_ready), 32'h0);
        chk("abort_rcv_ready", 32'(ard_receive_ready), 32'h0);
        chk("abort_err", 32'(err), 32'h0);
        chk("abort_queue", 32'(exp_q.size()), 32'h0);
        rst = 1'b0;
        cycle();
        chk("abort_rcv_rise", 32'(ard_receive_ready), 32'h1);
        fetch(16'h000F, 16'hBEEF, 16'h1234);
        chk("err_after_abort", 32'(err), 32'h0);

        cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
